wb_inst_responder: RTL
======================

# wb_inst_responder

Synthesizable Wishbone slave that feeds a core's instruction/data fetch port from a driver-loaded instruction FIFO, generalising fixed single-lane NOP-padded stimulus injection to a parametrised bus width, FIFO depth, ack latency and lane-packing mode. It sits between the UVM driver, which pushes instruction words, and the DUT's Wishbone master port. Core write cycles are captured and presented to the monitor. Starvation reads are counted.

## Interface
- DATA_W, 128: Wishbone data width; multiple of INST_W.
- INST_W, 32: instruction word width; LANES = DATA_W/INST_W.
- DEPTH, 8: instruction FIFO depth; power of two, ≥2.
- ACK_LAT, 1: cycles from request sample to ack; 1..15.
- PACK, 0: 0 = one instruction per read in lane 0; 1 = up to LANES instructions per read.
- NOP_WORD, 32'hF0081003: filler for unused or starved lanes.

Ports:
- i_clk  in  1  sole clock, all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_inst_valid  in  1  driver push request.
- i_inst  in  INST_W  pushed instruction.
- o_inst_ready  out  1  FIFO not full and not in reset.
- o_fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone cycle, strobe, write-enable.
- i_wb_adr  in  32  address.
- i_wb_sel  in  DATA_W/8  byte selects.
- i_wb_dat  in  DATA_W  write data from core.
- o_wb_dat  out  DATA_W  read data to core.
- o_wb_ack, o_wb_err  out  1  single-cycle termination.
- o_wr_valid  out  1  one-cycle pulse, captured write.
- o_wr_adr  out  32, o_wr_sel  out  DATA_W/8, o_wr_dat  out  DATA_W  captured write.
- o_starve_cnt  out  16  saturating count of reads that found the FIFO empty.

## Operation
- FIFO: push when i_inst_valid && o_inst_ready. Pop only in ACK state of a read.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on i_wb_cyc && i_wb_stb, latch we/adr/sel/dat. Go to ACK if ACK_LAT==1, else WAIT with counter = ACK_LAT-1.
  - WAIT: decrement the counter; go to ACK when it reaches 1. If i_wb_cyc drops, abort to IDLE with no ack, no pop, no capture.
  - ACK: terminate for exactly one cycle, then go to IDLE.
- Read termination (PACK=0):
  - o_wb_dat lane 0 (bits INST_W-1:0) = FIFO head, popped. Lanes 1..LANES-1 = NOP_WORD.
- Read termination (PACK=1):
  - k = min(count, LANES) words are popped in order into lanes 0..k-1. The remaining lanes are NOP_WORD.
- Empty FIFO at read termination: all lanes NOP_WORD, o_starve_cnt += 1, saturating at 16'hFFFF.
- Write termination with i_wb_sel != 0: o_wb_ack=1 and o_wr_valid=1 in the same cycle, with the latched adr/sel/dat. No FIFO change.
- Write with i_wb_sel == 0: o_wb_err=1 instead of ack. No capture.
- o_wb_dat holds its last value outside the ACK state.

## Timing
- Reset values:
  - All outputs 0, including o_inst_ready, o_fifo_count, o_wb_dat and o_starve_cnt.
  - FSM in IDLE, FIFO empty.
  - o_inst_ready rises the first cycle after i_rst deasserts.
- Latency: request first visible in IDLE at cycle t gives ack/err high in cycle t+ACK_LAT. The minimum request spacing is ACK_LAT+1 cycles. stb is ignored during the ACK cycle.
- Push and pop in the same cycle:
  - The pop sees the pre-push occupancy. An empty FIFO therefore returns NOP and counts as starvation, and the pushed word remains.
  - o_fifo_count = old + pushed − popped.
- Full FIFO: o_inst_ready=0. A pop in that cycle does not raise ready until the next cycle.
- Pointers wrap modulo DEPTH. Count distinguishes full from empty.
- i_rst mid-transaction: FSM goes to IDLE and the FIFO is flushed. No ack or err is issued for the pending request.

## Test plan
- Reset, then push 32'h00000013, then issue one read, with PACK=0 and ACK_LAT=1 → ack one cycle after stb. o_wb_dat = {3×32'hF0081003, 32'h00000013}. o_fifo_count 1→0.
- PACK=1, push A1,A2,A3,A4,A5, then issue one read → o_wb_dat = {A4,A3,A2,A1}, count=1. A second read returns {NOP,NOP,NOP,A5}.
- Read with the FIFO empty, repeated 3 times → every lane is NOP_WORD and o_starve_cnt=3.
- ACK_LAT=4, write to adr 32'h100 with sel 16'h000F and dat 128'hDEAD → ack at t+4. o_wr_valid pulses with the same adr/sel/dat. A write with sel=0 gives o_wb_err at t+4 and no o_wr_valid.
- DEPTH=8: push 8 words → o_inst_ready=0. A read pops one, ready returns the next cycle, and a ninth push wraps the pointer. The first-in order is preserved across 9 reads.
- ACK_LAT=3, drop i_wb_cyc in WAIT → no ack and count unchanged. Assert i_rst mid-WAIT → next cycle count=0, o_starve_cnt=0, and no ack.

Source files
------------

// File: rtl/wb_inst_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_inst_responder_if : Wishbone classic bus between a core master and the
//                        instruction responder slave.
// Revision 1.0
// ---------------------------------------------------------------------------
interface wb_inst_responder_if #(
    parameter int DATA_W = 128
);
    logic                i_wb_cyc;
    logic                i_wb_stb;
    logic                i_wb_we;
    logic [31:0]         i_wb_adr;
    logic [DATA_W/8-1:0] i_wb_sel;
    logic [DATA_W-1:0]   i_wb_dat;
    logic [DATA_W-1:0]   o_wb_dat;
    logic                o_wb_ack;
    logic                o_wb_err;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_sel, i_wb_dat,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_sel, i_wb_dat,
        output o_wb_dat, o_wb_ack, o_wb_err
    );
endinterface
`default_nettype wire

// File: rtl/wb_inst_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_inst_responder : Wishbone slave answering core reads from a driver-fed
//                     instruction FIFO and capturing core writes.
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_inst_responder #(
    parameter int               DATA_W   = 128,
    parameter int               INST_W   = 32,
    parameter int               DEPTH    = 8,
    parameter int               ACK_LAT  = 1,
    parameter int               PACK     = 0,
    parameter logic [INST_W-1:0] NOP_WORD = 32'hF0081003
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst,
    input  wire logic                  i_inst_valid,
    input  wire logic [INST_W-1:0]     i_inst,
    output logic                       o_inst_ready,
    output logic [$clog2(DEPTH):0]     o_fifo_count,
    wb_inst_responder_if.slave         wb,
    output logic                       o_wr_valid,
    output logic [31:0]                o_wr_adr,
    output logic [DATA_W/8-1:0]        o_wr_sel,
    output logic [DATA_W-1:0]          o_wr_dat,
    output logic [15:0]                o_starve_cnt
);
    localparam int LANES      = DATA_W / INST_W;
    localparam int LANES_USED = (PACK != 0) ? LANES : 1;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int SEL_W      = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          lat_q, lat_d;
    logic                req_we_q, req_we_d;
    logic [31:0]         req_adr_q, req_adr_d;
    logic [SEL_W-1:0]    req_sel_q, req_sel_d;
    logic [DATA_W-1:0]   req_dat_q, req_dat_d;
    logic [INST_W-1:0]   mem_q [DEPTH];
    logic [INST_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_idx;
    logic [CNT_W-1:0]    count_q, count_d, pop_n;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   wb_dat_q, wb_dat_d;
    logic                ack_q, ack_d, err_q, err_d;
    logic                wr_valid_q, wr_valid_d;
    logic [31:0]         wr_adr_q, wr_adr_d;
    logic [SEL_W-1:0]    wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;
    logic [15:0]         starve_q, starve_d;

    logic                push, term, t_we;
    logic [31:0]         t_adr;
    logic [SEL_W-1:0]    t_sel;
    logic [DATA_W-1:0]   t_dat;
    int                  k_i;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        req_we_d   = req_we_q;
        req_adr_d  = req_adr_q;
        req_sel_d  = req_sel_q;
        req_dat_d  = req_dat_q;
        mem_d      = mem_q;
        wb_dat_d   = wb_dat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        wr_valid_d = 1'b0;
        wr_adr_d   = wr_adr_q;
        wr_sel_d   = wr_sel_q;
        wr_dat_d   = wr_dat_q;
        starve_d   = starve_q;
        pop_n      = '0;
        rd_idx     = rd_ptr_q;
        k_i        = 0;
        term       = 1'b0;
        t_we       = req_we_q;
        t_adr      = req_adr_q;
        t_sel      = req_sel_q;
        t_dat      = req_dat_q;
        push       = i_inst_valid && ready_q;

        case (state_q)
            S_IDLE: begin
                if (wb.i_wb_cyc && wb.i_wb_stb) begin
                    req_we_d  = wb.i_wb_we;
                    req_adr_d = wb.i_wb_adr;
                    req_sel_d = wb.i_wb_sel;
                    req_dat_d = wb.i_wb_dat;
                    if (ACK_LAT == 1) begin
                        // Zero-wait requests terminate from the live bus values.
                        term  = 1'b1;
                        t_we  = wb.i_wb_we;
                        t_adr = wb.i_wb_adr;
                        t_sel = wb.i_wb_sel;
                        t_dat = wb.i_wb_dat;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = 4'(ACK_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!wb.i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (lat_q == 4'd1) begin
                    term = 1'b1;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Termination outputs are registered, so they are computed on entry to ACK.
        if (term) begin
            state_d = S_ACK;
            if (t_we) begin
                if (|t_sel) begin
                    ack_d      = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_adr_d   = t_adr;
                    wr_sel_d   = t_sel;
                    wr_dat_d   = t_dat;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                ack_d = 1'b1;
                if (count_q == '0 && starve_q != 16'hFFFF) begin
                    starve_d = starve_q + 16'd1;
                end
                k_i   = (int'(count_q) < LANES_USED) ? int'(count_q) : LANES_USED;
                pop_n = CNT_W'(k_i);
                for (int l = 0; l < LANES; l++) begin
                    rd_idx = rd_ptr_q + PTR_W'(l);
                    wb_dat_d[l*INST_W +: INST_W] = (l < k_i) ? mem_q[rd_idx] : NOP_WORD;
                end
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = i_inst;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
        count_d  = count_q + CNT_W'(push) - pop_n;
        ready_d  = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            req_we_q   <= 1'b0;
            req_adr_q  <= '0;
            req_sel_q  <= '0;
            req_dat_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            wb_dat_q   <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_adr_q   <= '0;
            wr_sel_q   <= '0;
            wr_dat_q   <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            req_we_q   <= req_we_d;
            req_adr_q  <= req_adr_d;
            req_sel_q  <= req_sel_d;
            req_dat_q  <= req_dat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            wb_dat_q   <= wb_dat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_adr_q   <= wr_adr_d;
            wr_sel_q   <= wr_sel_d;
            wr_dat_q   <= wr_dat_d;
            starve_q   <= starve_d;
        end
    end

    assign o_inst_ready = ready_q;
    assign o_fifo_count = count_q;
    assign wb.o_wb_dat  = wb_dat_q;
    assign wb.o_wb_ack  = ack_q;
    assign wb.o_wb_err  = err_q;
    assign o_wr_valid   = wr_valid_q;
    assign o_wr_adr     = wr_adr_q;
    assign o_wr_sel     = wr_sel_q;
    assign o_wr_dat     = wr_dat_q;
    assign o_starve_cnt = starve_q;
endmodule
`default_nettype wire
